// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and small helpers, used by the timing
// generator and by the color mapper.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  typedef logic [CNT_W-1:0] coord_t;

  // Registered per-pixel flags; all move together so they share one register.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic frame_end;
    logic frame_start;
  } vid_flags_t;

  localparam vid_flags_t FLAGS_RESET = '{hs: 1'b1, vs: 1'b1, blank: 1'b1,
                                         frame_end: 1'b0, frame_start: 1'b0};

  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the video timing outputs: the generator drives it, the color
// mapper and DAC side consume it.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pixel_clk;
  logic   pixel_ce;
  coord_t draw_x;
  coord_t draw_y;
  logic   hs;
  logic   vs;
  logic   blank;
  logic   frame_end;
  logic   frame_start;

  modport master (
    output pixel_clk, pixel_ce, draw_x, draw_y, hs, vs, blank, frame_end, frame_start
  );

  modport slave (
    input  pixel_clk, pixel_ce, draw_x, draw_y, hs, vs, blank, frame_end, frame_start
  );

endinterface

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps TERMINAL -> 0 and flags the wrapping cycle.
// count_next exposes the value the counter will hold after this edge.
module wrap_counter #(
  parameter int               WIDTH    = 10,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    // NOTE: every signal gets a default before the if/else so no path leaves it unassigned (no latch).
    count_d = count_q;
    wrap    = 1'b0;
    if (en) begin
      if (count_q == TERMINAL) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: Clk/2 pixel enable, horizontal/vertical counters and
// sync/blank/frame flags registered from next-counter values (zero skew).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_clk,
  output logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_end,
  output logic       frame_start
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_LIM  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_LIM  = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_FIN = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_FIN = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t V_LAST_VIS = coord_t'(V_VISIBLE - 1);

  logic       div_q;
  logic       div_d;
  coord_t     x_q;
  coord_t     y_q;
  coord_t     x_next;
  coord_t     y_next;
  logic       h_wrap;
  logic       v_wrap;
  vid_flags_t flags_q;
  vid_flags_t flags_d;

  assign div_d = ~div_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) div_q <= 1'b0;
    else       div_q <= div_d;
  end

  wrap_counter #(
    .WIDTH   (CNT_W),
    .TERMINAL(H_LAST)
  ) u_h_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .en        (div_q),
    .count     (x_q),
    .count_next(x_next),
    .wrap      (h_wrap)
  );

  // The vertical counter steps exactly on the horizontal wrap edge.
  wrap_counter #(
    .WIDTH   (CNT_W),
    .TERMINAL(V_LAST)
  ) u_v_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .en        (h_wrap),
    .count     (y_q),
    .count_next(y_next),
    .wrap      (v_wrap)
  );

  // Flags are decoded from next-counter values so the register lines them up
  // with DrawX/DrawY; on non-advance edges next equals current, so they hold.
  always_comb begin
    flags_d             = flags_q;
    flags_d.hs          = ~in_range(x_next, H_SYNC_BEG, H_SYNC_FIN);
    flags_d.vs          = ~in_range(y_next, V_SYNC_BEG, V_SYNC_FIN);
    flags_d.blank       = (x_next < H_VIS_LIM) && (y_next < V_VIS_LIM);
    flags_d.frame_end   = h_wrap && (y_q == V_LAST_VIS);
    flags_d.frame_start = h_wrap && v_wrap;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) flags_q <= FLAGS_RESET;
    else       flags_q <= flags_d;
  end

  assign pixel_clk   = div_q;
  assign pixel_ce    = div_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = flags_q.hs;
  assign vs          = flags_q.vs;
  assign blank       = flags_q.blank;
  assign frame_end   = flags_q.frame_end;
  assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; horizontal timing at full size, vertical
// shortened to 15 lines (8 visible, vsync on lines 10-11) to keep runs short.
module tb_vga_timing_gen;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(8),   .V_FP(2),  .V_SYNC(2),  .V_BP(3)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pixel_clk  (vif.pixel_clk),
    .pixel_ce   (vif.pixel_ce),
    .DrawX      (vif.draw_x),
    .DrawY      (vif.draw_y),
    .hs         (vif.hs),
    .vs         (vif.vs),
    .blank      (vif.blank),
    .frame_end  (vif.frame_end),
    .frame_start(vif.frame_start)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reset released on a falling edge; afterwards sample n is the n-th negedge.
  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_pclk;
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    n_checks++; if (vif.draw_x !== 10'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", vif.draw_x); end
    n_checks++; if (vif.draw_y !== 10'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", vif.draw_y); end
    n_checks++; if ({vif.hs, vif.vs, vif.blank} !== 3'b111) begin n_fail++; $display("FAIL reset_hs_vs_blank got %b want 111", {vif.hs, vif.vs, vif.blank}); end
    n_checks++; if ({vif.frame_end, vif.frame_start, vif.pixel_clk} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses_pclk got %b want 000", {vif.frame_end, vif.frame_start, vif.pixel_clk}); end
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++; if (vif.draw_x !== 10'd0) begin n_fail++; $display("FAIL first_edge_x got %0d want 0", vif.draw_x); end
    @(negedge Clk);
    n_checks++; if (vif.draw_x !== 10'd1) begin n_fail++; $display("FAIL second_edge_x got %0d want 1", vif.draw_x); end
    exp_pclk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      exp_pclk = ~exp_pclk;
      n_checks++; if (vif.pixel_clk !== exp_pclk || vif.pixel_ce !== exp_pclk) begin
        n_fail++; $display("FAIL pclk_toggle[%0d] got clk=%b ce=%b want %b", i, vif.pixel_clk, vif.pixel_ce, exp_pclk);
      end
    end
  endtask

  task automatic test_line();
    int     hs_low;
    logic   hs_seen, blank_seen, prev_blank;
    logic [9:0] hs_x, blank_x;
    hs_low = 0; hs_seen = 1'b0; blank_seen = 1'b0; prev_blank = 1'b1;
    hs_x = '0; blank_x = '0;
    do_reset();
    for (int n = 1; n <= 1600; n++) begin
      @(negedge Clk);
      if (vif.hs === 1'b0) begin
        hs_low++;
        if (!hs_seen) begin hs_seen = 1'b1; hs_x = vif.draw_x; end
      end
      if (prev_blank === 1'b1 && vif.blank === 1'b0 && !blank_seen) begin
        blank_seen = 1'b1; blank_x = vif.draw_x;
      end
      prev_blank = vif.blank;
    end
    n_checks++; if (hs_low != 192) begin n_fail++; $display("FAIL hs_low_clks got %0d want 192", hs_low); end
    n_checks++; if (!hs_seen || hs_x !== 10'd656) begin n_fail++; $display("FAIL hs_start_x got %0d (seen %b) want 656", hs_x, hs_seen); end
    n_checks++; if (!blank_seen || blank_x !== 10'd640) begin n_fail++; $display("FAIL blank_fall_x got %0d (seen %b) want 640", blank_x, blank_seen); end
    n_checks++; if (vif.draw_x !== 10'd0 || vif.draw_y !== 10'd1) begin n_fail++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", vif.draw_x, vif.draw_y); end
    n_checks++; if (vif.blank !== 1'b1 || vif.hs !== 1'b1) begin n_fail++; $display("FAIL line1_flags got blank=%b hs=%b want 1 1", vif.blank, vif.hs); end
  endtask

  task automatic test_frame();
    int   vs_ce, fe_cnt, fe_n, fs_cnt, fs_n;
    logic vs_seen;
    logic [9:0] vs_x, vs_y, fe_y;
    vs_ce = 0; fe_cnt = 0; fe_n = 0; fs_cnt = 0; fs_n = 0;
    vs_seen = 1'b0; vs_x = '0; vs_y = '0; fe_y = '0;
    do_reset();
    for (int n = 1; n <= 24001; n++) begin
      @(negedge Clk);
      if (vif.vs === 1'b0) begin
        if (vif.pixel_ce === 1'b1) vs_ce++;
        if (!vs_seen) begin vs_seen = 1'b1; vs_x = vif.draw_x; vs_y = vif.draw_y; end
      end
      if (vif.frame_end === 1'b1) begin fe_cnt++; fe_n = n; fe_y = vif.draw_y; end
      if (vif.frame_start === 1'b1) begin fs_cnt++; fs_n = n; end
    end
    n_checks++; if (vs_ce != 1600) begin n_fail++; $display("FAIL vs_low_ce got %0d want 1600", vs_ce); end
    n_checks++; if (!vs_seen || vs_x !== 10'd0 || vs_y !== 10'd10) begin n_fail++; $display("FAIL vs_start got (%0d,%0d) want (0,10)", vs_x, vs_y); end
    n_checks++; if (fe_cnt != 1 || fe_n != 12800) begin n_fail++; $display("FAIL frame_end got count=%0d at=%0d want 1 at 12800", fe_cnt, fe_n); end
    n_checks++; if (fe_y !== 10'd8) begin n_fail++; $display("FAIL frame_end_y got %0d want 8", fe_y); end
    n_checks++; if (fs_cnt != 1 || fs_n != 24000) begin n_fail++; $display("FAIL frame_start got count=%0d at=%0d want 1 at 24000", fs_cnt, fs_n); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (23999) @(negedge Clk);
    n_checks++; if (vif.draw_x !== 10'd799 || vif.draw_y !== 10'd14) begin n_fail++; $display("FAIL pre_wrap got (%0d,%0d) want (799,14)", vif.draw_x, vif.draw_y); end
    n_checks++; if ({vif.blank, vif.hs, vif.vs, vif.frame_start} !== 4'b0110) begin n_fail++; $display("FAIL pre_wrap_flags got %b want 0110", {vif.blank, vif.hs, vif.vs, vif.frame_start}); end
    @(negedge Clk);
    n_checks++; if (vif.draw_x !== 10'd0 || vif.draw_y !== 10'd0) begin n_fail++; $display("FAIL wrap_xy got (%0d,%0d) want (0,0)", vif.draw_x, vif.draw_y); end
    n_checks++; if ({vif.blank, vif.hs, vif.vs, vif.frame_start} !== 4'b1111) begin n_fail++; $display("FAIL wrap_flags got %b want 1111", {vif.blank, vif.hs, vif.vs, vif.frame_start}); end
    @(negedge Clk);
    n_checks++; if (vif.frame_start !== 1'b0 || vif.draw_x !== 10'd0) begin n_fail++; $display("FAIL wrap_fs_width got fs=%b x=%0d want 0 0", vif.frame_start, vif.draw_x); end
  endtask

  task automatic test_mid_reset();
    int pulses;
    pulses = 0;
    do_reset();
    repeat (8600) @(negedge Clk);
    n_checks++; if (vif.draw_x !== 10'd300 || vif.draw_y !== 10'd5) begin n_fail++; $display("FAIL mid_pos got (%0d,%0d) want (300,5)", vif.draw_x, vif.draw_y); end
    #2;
    Reset = 1'b1;
    #1;
    n_checks++; if (vif.draw_x !== 10'd0 || vif.draw_y !== 10'd0) begin n_fail++; $display("FAIL mid_reset_xy got (%0d,%0d) want (0,0)", vif.draw_x, vif.draw_y); end
    n_checks++; if ({vif.hs, vif.vs, vif.blank, vif.frame_end, vif.frame_start, vif.pixel_clk} !== 6'b111000) begin
      n_fail++; $display("FAIL mid_reset_flags got %b want 111000", {vif.hs, vif.vs, vif.blank, vif.frame_end, vif.frame_start, vif.pixel_clk});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (vif.frame_end === 1'b1 || vif.frame_start === 1'b1) pulses++;
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (vif.frame_end === 1'b1 || vif.frame_start === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL mid_reset_pulses got %0d want 0", pulses); end
    n_checks++; if (vif.draw_x !== 10'd2 || vif.draw_y !== 10'd0) begin n_fail++; $display("FAIL post_reset_xy got (%0d,%0d) want (2,0)", vif.draw_x, vif.draw_y); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch and sync widths in pixels (total 800).
REQ-003 SHALL have parameter V_VISIBLE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical lines (total 525).
REQ-004 SHALL have port Clk  input  1  system clock (50 MHz).
REQ-005 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pixel_clk  output  1  Clk divided by 2, for the DAC.
REQ-007 SHALL have port pixel_ce  output  1  one-Clk enable marking each pixel advance.
REQ-008 SHALL have port DrawX  output  10  current horizontal count, 0..799.
REQ-009 SHALL have port DrawY  output  10  current vertical count, 0..524.
REQ-010 SHALL have port hs  output  1  horizontal sync, active-low.
REQ-011 SHALL have port vs  output  1  vertical sync, active-low.
REQ-012 SHALL have port blank  output  1  high while in the visible region (color enable, consumed by the color mapper).
REQ-013 SHALL have port frame_end  output  1  one-Clk pulse at start of vertical blanking, used by game logic to update positions.
REQ-014 SHALL have port frame_start  output  1  one-Clk pulse when counters wrap to (0,0).

Function
REQ-015 SHALL toggle internal divider bit div every Clk; pixel_clk = div; pixel_ce = div.
REQ-016 SHALL advance DrawX only on Clk edges where pixel_ce = 1; DrawX wraps 799 -> 0.
REQ-017 SHALL advance DrawY by 1 on the same edge DrawX wraps; DrawY wraps 524 -> 0 at the same edge.
REQ-018 SHALL register hs, vs, blank from the next counter values so they change on the same Clk edge as DrawX/DrawY (zero relative skew).
REQ-019 SHALL drive hs = 0 exactly when DrawX in [656, 751], else 1.
REQ-020 SHALL drive vs = 0 exactly when DrawY in [490, 491], else 1.
REQ-021 SHALL drive blank = 1 exactly when DrawX < 640 and DrawY < 480.
REQ-022 SHALL assert frame_end for one Clk cycle on the edge where DrawY goes 479 -> 480.
REQ-023 SHALL assert frame_start for one Clk cycle on the edge where (DrawX,DrawY) goes (799,524) -> (0,0); never asserted by reset itself.
REQ-024 SHALL hold all outputs except pixel_clk/pixel_ce stable on Clk edges where pixel_ce = 0.
REQ-025 SHALL derive all boundary values from the parameters; widths fixed at 10 bits, totals must be ≤ 1024.

Reset
REQ-026 SHALL on Reset = 1, asynchronously force div=0, DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_end=0, frame_start=0.
REQ-027 SHALL after Reset deasserts, make the first DrawX advance (0 -> 1) on the second rising Clk edge.
REQ-028 SHALL on Reset asserted mid-frame, abandon the frame immediately with no frame_start/frame_end pulse produced by the reset.

Structure
REQ-029 SHALL place timing constants (totals, sync start/end, visible limits) in shared package vga_pkg, also imported by the color mapper.
REQ-030 SHALL instantiate one sub-module wrap_counter (parameterised width and terminal value, enable input, wrap output pulse) twice: horizontal and vertical.
REQ-031 SHALL contain no multipliers or RAM; counters, comparators and registers only.

Verification
REQ-032 SHALL verify: Reset pulse then release -> DrawX=0 for 2 Clk edges, 1 after 2nd edge, pixel_clk toggles every Clk.
REQ-033 SHALL verify: run one line -> hs low for exactly 192 Clk cycles starting when DrawX becomes 656; blank falls when DrawX becomes 640.
REQ-034 SHALL verify: run one frame -> vs low for exactly 1600 pixel_ce pulses (2 lines), starting at DrawY=490, DrawX=0.
REQ-035 SHALL verify: full frame -> exactly one frame_end at DrawY 479->480 and one frame_start after 420000 pixel_ce pulses (840000 Clk).
REQ-036 SHALL verify: Reset asserted at DrawX=300, DrawY=200 asynchronously mid-cycle -> outputs to reset values without waiting for a Clk edge, no pulses.
REQ-037 SHALL verify: wrap at (799,524) -> next (0,0), blank=1, hs=1, vs=1, frame_start high one Clk only.
